// File: rtl/fb_cu_pipe.sv
// Pipelined control unit: decodes ID, inserts load-use bubbles, and holds
// the ID/EX control bundle for the full latency of a multi-cycle mul/div.
module fb_cu_pipe #(
  parameter int ENABLE_M = 1,
  parameter int MD_LAT   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic        flush,
  output logic        id_stall,
  output logic        md_busy,
  output logic        ex_valid,
  output logic [4:0]  ex_rd,
  output logic [1:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_alu_res_src,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_mem_to_reg,
  output logic        ex_reg_write,
  output logic        ex_jalr_en,
  output logic        ex_md_en,
  output logic        ex_illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       alu_res_src;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       mem_to_reg;
    logic       reg_write;
    logic       jalr_en;
    logic       md_en;
    logic       illegal;
  } ctrl_t;

  typedef enum logic {IDLE, MD_BUSY} state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       md_busy_q;
  ctrl_t      ex_q;
  ctrl_t      dec_d;
  logic       use_rs1, use_rs2;
  logic       hazard;
  logic       issue;

  logic [6:0] opc, f7;
  logic [4:0] rs1, rs2;
  logic       unused_funct3;

  assign opc           = id_inst[6:0];
  assign f7            = id_inst[31:25];
  assign rs1           = id_inst[19:15];
  assign rs2           = id_inst[24:20];
  assign unused_funct3 = ^id_inst[14:12];

  always_comb begin
    dec_d       = '0;
    dec_d.valid = 1'b1;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    case (opc)
      OP_R: begin
        if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
          dec_d.alu_op    = 2'b10;
          dec_d.reg_write = 1'b1;
          use_rs1         = 1'b1;
          use_rs2         = 1'b1;
        end else if (ENABLE_M != 0 && f7 == 7'b0000001) begin
          dec_d.alu_op    = 2'b10;
          dec_d.reg_write = 1'b1;
          dec_d.md_en     = 1'b1;
          use_rs1         = 1'b1;
          use_rs2         = 1'b1;
        end else begin
          dec_d.illegal = 1'b1;
        end
      end
      OP_I: begin
        dec_d.alu_op    = 2'b11;
        dec_d.alu_src   = 1'b1;
        dec_d.reg_write = 1'b1;
        use_rs1         = 1'b1;
      end
      OP_LOAD: begin
        dec_d.alu_src    = 1'b1;
        dec_d.mem_read   = 1'b1;
        dec_d.mem_to_reg = 1'b1;
        dec_d.reg_write  = 1'b1;
        use_rs1          = 1'b1;
      end
      OP_STORE: begin
        dec_d.alu_src   = 1'b1;
        dec_d.mem_write = 1'b1;
        use_rs1         = 1'b1;
        use_rs2         = 1'b1;
      end
      OP_B: begin
        dec_d.alu_op = 2'b01;
        dec_d.branch = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
      end
      OP_JALR: begin
        dec_d.alu_res_src = 1'b1;
        dec_d.jalr_en     = 1'b1;
        dec_d.reg_write   = 1'b1;
        use_rs1           = 1'b1;
      end
      OP_JAL: begin
        dec_d.alu_res_src = 1'b1;
        dec_d.reg_write   = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec_d.alu_src   = 1'b1;
        dec_d.reg_write = 1'b1;
      end
      default: dec_d.illegal = 1'b1;
    endcase
    dec_d.rd = dec_d.reg_write ? id_inst[11:7] : 5'd0;
  end

  // EX can only hold a load while IDLE, so the hazard is naturally inert during MD_BUSY
  assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid &
                  ((use_rs1 & (rs1 == ex_q.rd)) | (use_rs2 & (rs2 == ex_q.rd)));
  assign issue    = id_valid & ~hazard;
  assign id_stall = (md_busy_q | hazard) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      md_busy_q <= 1'b0;
      ex_q      <= '0;
    end else if (flush) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      md_busy_q <= 1'b0;
      ex_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ex_q <= issue ? dec_d : ctrl_t'('0);
          if (issue && dec_d.md_en) begin
            state_q   <= MD_BUSY;
            cnt_q     <= 4'(MD_LAT - 1);
            md_busy_q <= 1'b1;
          end
        end
        MD_BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q   <= IDLE;
            md_busy_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md_busy        = md_busy_q;
  assign ex_valid       = ex_q.valid;
  assign ex_rd          = ex_q.rd;
  assign ex_alu_op      = ex_q.alu_op;
  assign ex_alu_src     = ex_q.alu_src;
  assign ex_alu_res_src = ex_q.alu_res_src;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_mem_write   = ex_q.mem_write;
  assign ex_branch      = ex_q.branch;
  assign ex_mem_to_reg  = ex_q.mem_to_reg;
  assign ex_reg_write   = ex_q.reg_write;
  assign ex_jalr_en     = ex_q.jalr_en;
  assign ex_md_en       = ex_q.md_en;
  assign ex_illegal     = ex_q.illegal;

endmodule

// File: tb/tb_fb_cu_pipe.sv
// Directed bench for fb_cu_pipe: expected ID/EX bundles are queued as each
// instruction is driven and compared one edge later.
module tb_fb_cu_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_inst = 32'h0;
  logic        flush = 1'b0;

  logic        id_stall, md_busy, ex_valid, ex_alu_src, ex_alu_res_src, ex_mem_read;
  logic        ex_mem_write, ex_branch, ex_mem_to_reg, ex_reg_write, ex_jalr_en, ex_md_en, ex_illegal;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_alu_op;

  logic        id_stall0, md_busy0, ex_valid0, ex_alu_src0, ex_alu_res_src0, ex_mem_read0;
  logic        ex_mem_write0, ex_branch0, ex_mem_to_reg0, ex_reg_write0, ex_jalr_en0, ex_md_en0, ex_illegal0;
  logic [4:0]  ex_rd0;
  logic [1:0]  ex_alu_op0;

  fb_cu_pipe #(.ENABLE_M(1), .MD_LAT(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
    .id_stall(id_stall), .md_busy(md_busy), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_alu_res_src(ex_alu_res_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_jalr_en(ex_jalr_en),
    .ex_md_en(ex_md_en), .ex_illegal(ex_illegal)
  );

  fb_cu_pipe #(.ENABLE_M(0), .MD_LAT(4)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
    .id_stall(id_stall0), .md_busy(md_busy0), .ex_valid(ex_valid0), .ex_rd(ex_rd0),
    .ex_alu_op(ex_alu_op0), .ex_alu_src(ex_alu_src0), .ex_alu_res_src(ex_alu_res_src0),
    .ex_mem_read(ex_mem_read0), .ex_mem_write(ex_mem_write0), .ex_branch(ex_branch0),
    .ex_mem_to_reg(ex_mem_to_reg0), .ex_reg_write(ex_reg_write0), .ex_jalr_en(ex_jalr_en0),
    .ex_md_en(ex_md_en0), .ex_illegal(ex_illegal0)
  );

  always #5 clk = ~clk;

  logic [17:0] obs, obs0;
  assign obs  = {ex_valid, ex_rd, ex_alu_op, ex_alu_src, ex_alu_res_src, ex_mem_read,
                 ex_mem_write, ex_branch, ex_mem_to_reg, ex_reg_write, ex_jalr_en,
                 ex_md_en, ex_illegal};
  assign obs0 = {ex_valid0, ex_rd0, ex_alu_op0, ex_alu_src0, ex_alu_res_src0, ex_mem_read0,
                 ex_mem_write0, ex_branch0, ex_mem_to_reg0, ex_reg_write0, ex_jalr_en0,
                 ex_md_en0, ex_illegal0};

  // Strobe order: src, res_src, mem_read, mem_write, branch, mem_to_reg, reg_write, jalr, md, illegal
  localparam logic [9:0] S_SRC  = 10'b1000000000;
  localparam logic [9:0] S_RES  = 10'b0100000000;
  localparam logic [9:0] S_MR   = 10'b0010000000;
  localparam logic [9:0] S_MW   = 10'b0001000000;
  localparam logic [9:0] S_BR   = 10'b0000100000;
  localparam logic [9:0] S_M2R  = 10'b0000010000;
  localparam logic [9:0] S_RW   = 10'b0000001000;
  localparam logic [9:0] S_JALR = 10'b0000000100;
  localparam logic [9:0] S_MD   = 10'b0000000010;
  localparam logic [9:0] S_ILL  = 10'b0000000001;

  function automatic logic [17:0] X(input logic [4:0] rd, input logic [1:0] op, input logic [9:0] s);
    return {1'b1, rd, op, s};
  endfunction

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_LW5   = 32'h0000A283;
  localparam logic [31:0] I_ADD6  = 32'h00228333;
  localparam logic [31:0] I_LW0   = 32'h0000A003;
  localparam logic [31:0] I_ADDX0 = 32'h00200333;
  localparam logic [31:0] I_ADDR2 = 32'h00510333;
  localparam logic [31:0] I_MUL   = 32'h022083B3;
  localparam logic [31:0] I_ADDI  = 32'h00108213;
  localparam logic [31:0] I_LUI   = 32'h12345437;
  localparam logic [31:0] I_AUIPC = 32'h00001497;
  localparam logic [31:0] I_JAL   = 32'h000000EF;
  localparam logic [31:0] I_JALR  = 32'h00008067;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_BEQ   = 32'h00208063;
  localparam logic [31:0] I_BAD   = 32'h0000007F;
  localparam logic [31:0] I_BADF7 = 32'h042081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;

  localparam logic [17:0] E_ADD   = X(5'd3, 2'b10, S_RW);
  localparam logic [17:0] E_LW5   = X(5'd5, 2'b00, S_SRC | S_MR | S_M2R | S_RW);
  localparam logic [17:0] E_ADD6  = X(5'd6, 2'b10, S_RW);
  localparam logic [17:0] E_LW0   = X(5'd0, 2'b00, S_SRC | S_MR | S_M2R | S_RW);
  localparam logic [17:0] E_MUL   = X(5'd7, 2'b10, S_RW | S_MD);
  localparam logic [17:0] E_ADDI  = X(5'd4, 2'b11, S_SRC | S_RW);
  localparam logic [17:0] E_LUI   = X(5'd8, 2'b00, S_SRC | S_RW);
  localparam logic [17:0] E_AUIPC = X(5'd9, 2'b00, S_SRC | S_RW);
  localparam logic [17:0] E_JAL   = X(5'd1, 2'b00, S_RES | S_RW);
  localparam logic [17:0] E_JALR  = X(5'd0, 2'b00, S_RES | S_RW | S_JALR);
  localparam logic [17:0] E_SW    = X(5'd0, 2'b00, S_SRC | S_MW);
  localparam logic [17:0] E_BEQ   = X(5'd0, 2'b01, S_BR);
  localparam logic [17:0] E_ILL   = X(5'd0, 2'b00, S_ILL);
  localparam logic [17:0] E_SUB   = X(5'd3, 2'b10, S_RW);
  localparam logic [17:0] BUB     = 18'h0;

  int total = 0;
  int bad   = 0;
  logic [18:0] sb[$];

  task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // One ID cycle: drive at negedge, check the combinational stall, then
  // compare {md_busy, ex bundle} just after the following rising edge.
  task automatic cyc(input string tag, input logic v, input logic [31:0] inst,
                     input logic fl, input logic es, input logic [18:0] want);
    logic [18:0] w;
    @(negedge clk);
    id_valid = v;
    id_inst  = inst;
    flush    = fl;
    #1;
    chk({tag, "_stall"}, {18'b0, id_stall}, {18'b0, es});
    sb.push_back(want);
    @(posedge clk);
    #1;
    w = sb.pop_front();
    chk({tag, "_ex"}, {md_busy, obs}, w);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {md_busy, obs}, 19'h0);
    @(negedge clk);
    rst = 1'b0;

    cyc("add",      1, I_ADD,   0, 0, {1'b0, E_ADD});
    cyc("lw5",      1, I_LW5,   0, 0, {1'b0, E_LW5});
    cyc("lu_bub",   1, I_ADD6,  0, 1, {1'b0, BUB});
    cyc("lu_issue", 1, I_ADD6,  0, 0, {1'b0, E_ADD6});
    cyc("lw0",      1, I_LW0,   0, 0, {1'b0, E_LW0});
    cyc("x0_nohz",  1, I_ADDX0, 0, 0, {1'b0, E_ADD6});
    cyc("lw5b",     1, I_LW5,   0, 0, {1'b0, E_LW5});
    cyc("rs2_bub",  1, I_ADDR2, 0, 1, {1'b0, BUB});
    cyc("rs2_iss",  1, I_ADDR2, 0, 0, {1'b0, E_ADD6});

    cyc("mul",      1, I_MUL,   0, 0, {1'b1, E_MUL});
    chk("nom_mul_ex",    {md_busy0, obs0}, {1'b0, E_ILL});
    chk("nom_mul_stall", {18'b0, id_stall0}, 19'h0);
    cyc("mul_b1",   1, I_ADDI,  0, 1, {1'b1, E_MUL});
    cyc("mul_b2",   0, I_ADDI,  0, 1, {1'b1, E_MUL});
    cyc("mul_b3",   1, I_ADDI,  0, 1, {1'b0, E_MUL});
    cyc("mul_next", 1, I_ADDI,  0, 0, {1'b0, E_ADDI});

    cyc("fmul",     1, I_MUL,   0, 0, {1'b1, E_MUL});
    cyc("fmul_b1",  1, I_ADDI,  0, 1, {1'b1, E_MUL});
    cyc("fmul_fl",  1, I_ADDI,  1, 0, {1'b0, BUB});
    cyc("fmul_nx",  1, I_ADDI,  0, 0, {1'b0, E_ADDI});

    cyc("b2b_1",    1, I_MUL,   0, 0, {1'b1, E_MUL});
    cyc("b2b_h1",   1, I_MUL,   0, 1, {1'b1, E_MUL});
    cyc("b2b_h2",   1, I_MUL,   0, 1, {1'b1, E_MUL});
    cyc("b2b_h3",   1, I_MUL,   0, 1, {1'b0, E_MUL});
    cyc("b2b_2",    1, I_MUL,   0, 0, {1'b1, E_MUL});
    cyc("b2b_h4",   1, I_ADDI,  0, 1, {1'b1, E_MUL});
    cyc("b2b_fl",   1, I_ADDI,  1, 0, {1'b0, BUB});

    cyc("lui",      1, I_LUI,   0, 0, {1'b0, E_LUI});
    cyc("auipc",    1, I_AUIPC, 0, 0, {1'b0, E_AUIPC});
    cyc("jal",      1, I_JAL,   0, 0, {1'b0, E_JAL});
    cyc("jalr",     1, I_JALR,  0, 0, {1'b0, E_JALR});
    cyc("sw",       1, I_SW,    0, 0, {1'b0, E_SW});
    cyc("beq",      1, I_BEQ,   0, 0, {1'b0, E_BEQ});
    cyc("op7f",     1, I_BAD,   0, 0, {1'b0, E_ILL});
    cyc("badf7",    1, I_BADF7, 0, 0, {1'b0, E_ILL});
    cyc("sub",      1, I_SUB,   0, 0, {1'b0, E_SUB});
    cyc("idle_inv", 0, I_ADD,   0, 0, {1'b0, BUB});

    cyc("fh_lw",    1, I_LW5,   0, 0, {1'b0, E_LW5});
    cyc("fh_fl",    1, I_ADD6,  1, 0, {1'b0, BUB});
    cyc("fh_iss",   1, I_ADD6,  0, 0, {1'b0, E_ADD6});

    cyc("rmul",     1, I_MUL,   0, 0, {1'b1, E_MUL});
    @(negedge clk);
    id_valid = 1'b1;
    id_inst  = I_ADD;
    flush    = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", {md_busy, obs}, 19'h0);
    @(posedge clk);
    #1;
    chk("rst_hold", {md_busy, obs}, 19'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc("post_rst", 1, I_ADD,   0, 0, {1'b0, E_ADD});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fb_cu_pipe.md
# fb_cu_pipe

Registered, parametrised successor to the combinational control unit. It decodes the full 32-bit instruction in ID, detects load-use hazards against the instruction in EX, and inserts bubbles. It optionally recognises RV32M mul/div and holds EX for a fixed multi-cycle latency. Its outputs form the control half of the ID/EX pipeline register and feed EX/MEM/WB directly.

## Interface
Parameters:
- ENABLE_M, default 1: 1 decodes opcode 0110011 with funct7 0000001 as mul/div; 0 makes it illegal.
- MD_LAT, default 4: total EX occupancy of a mul/div in cycles; legal range 2..16.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  id_inst holds a valid instruction.
- id_inst  in  32  instruction in ID.
- flush  in  1  EX redirect (taken branch/jal/jalr); kills the ID/EX contents.
- id_stall  out  1  combinational; hold PC and IF/ID this cycle.
- md_busy  out  1  registered; a mul/div is occupying EX beyond its first cycle.
- ex_valid, ex_rd[4:0], ex_alu_op[1:0], ex_alu_src, ex_alu_res_src, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg, ex_reg_write, ex_jalr_en, ex_md_en, ex_illegal  out  registered ID/EX control bundle.

## Operation
- Decode classes by opcode:
  - R 0110011
  - I 0010011
  - load 0000011
  - store 0100011
  - B 1100011
  - jalr 1100111
  - jal 1101111
  - lui 0110111
  - auipc 0010111
- Any other opcode is illegal. R with funct7 outside {0000000, 0100000}, or outside {0000000, 0100000, 0000001} when ENABLE_M=1, is also illegal.
- alu_op encoding:
  - R: 10
  - B: 01
  - I: 11
  - load, store, lui, auipc, jal, jalr: 00
  - md: 10
- alu_src = I | store | load | lui | auipc.
- alu_res_src = jal | jalr.
- Memory, branch and write-back strobes:
  - mem_read = mem_to_reg = load
  - mem_write = store
  - branch = B
  - jalr_en = jalr
  - md_en = md
- reg_write = R | I | load | jalr | jal | lui | auipc | md.
- ex_rd = inst[11:7] when reg_write, else 0.
- Illegal instruction: ex_illegal=1, ex_valid=1, every other strobe 0.
- Register usage:
  - rs1 (inst[19:15]) is used by R, I, load, store, B, jalr, md.
  - rs2 (inst[24:20]) is used by R, store, B, md.
- Load-use hazard: ex_valid & ex_mem_read & ex_rd≠0 & id_valid & ((use_rs1 & rs1==ex_rd) | (use_rs2 & rs2==ex_rd)).
- FSM, two states:
  - IDLE: ID/EX loads the decoded bundle each cycle. It loads a bubble (ex_valid=0, all strobes 0, ex_rd=0) instead when id_valid=0 or a hazard is present.
  - Latching an md instruction loads the counter with MD_LAT-1 and moves to MD_BUSY.
  - MD_BUSY: md_busy=1 and ID/EX holds its value. The counter decrements each cycle; on reaching 0 the FSM returns to IDLE.
- id_stall = (md_busy | hazard) & ~flush.

## Timing
- Reset: every output and the counter are 0, FSM is IDLE; the reset takes effect asynchronously.
- Decode-to-EX latency is 1 cycle: an instruction present at edge N appears on ex_* after edge N.
- Load-use costs exactly 1 bubble. The held instruction issues on the next edge, because the bubble clears ex_mem_read.
- A mul/div occupies EX for exactly MD_LAT cycles. md_busy is high for the MD_LAT-1 cycles after the latch cycle. id_stall is high during those cycles. The instruction following the mul/div enters EX on the edge after md_busy falls.
- Back-to-back mul/div: the second is latched when the FSM returns to IDLE, and its own MD_LAT sequence starts.
- flush has highest priority. The next edge loads a bubble, zeroes the counter and forces IDLE, including mid-MD_BUSY. id_stall=0 while flush=1.
- Hazard and md_busy together: md_busy dominates and ID/EX holds; the hazard logic is inert because EX holds a non-load.
- ex_rd=0 (x0) never raises a hazard.
- id_valid=0 while in MD_BUSY has no effect; ID/EX still holds.

## Test plan
- Reset and plain issue: assert rst mid-run, then deassert and drive add x3,x1,x2 (0x002081B3) -> ex_* all 0 during reset; next cycle ex_valid=1, alu_op=10, reg_write=1, ex_rd=3.
- Load-use: lw x5,0(x1) then add x6,x5,x2 -> id_stall=1 for one cycle, one ex_valid=0 bubble, add issues the following cycle. Repeat with rd=x0 -> no stall.
- Mul/div with MD_LAT=4: mul x7,x1,x2 (0x022083B3) -> ex_md_en=1 for 4 consecutive cycles, md_busy=1 and id_stall=1 for 3, next instruction enters EX on cycle 5. With ENABLE_M=0 -> ex_illegal=1, reg_write=0, no stall.
- Flush mid-mul: flush on the second md_busy cycle -> next cycle ex_valid=0, md_busy=0, IDLE; the next instruction issues immediately.
- Coverage of lui, auipc, jal, jalr, sw, beq and opcode 0x7F -> every strobe matches the Operation rules; 0x7F gives ex_illegal=1 with all strobes 0.
